// File: rtl/grad_read_arbiter.sv
// Round-robin arbiter sharing one x/y gradient BRAM read port pair among NUM_REQ histogram engines.
// Optional GRAD_ARB_BURST_LOCK_EN lets the previous winner keep the port while it holds lock_in.
module grad_read_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_WIDTH   = 12,
   parameter int BIT_DEPTH    = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [NUM_REQ-1:0]            req_in,
   input  logic [NUM_REQ-1:0]            lock_in,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] x_addr_in,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] y_addr_in,
   output logic [NUM_REQ-1:0]            gnt_out,
   output logic [ADDR_WIDTH-1:0]         x_bram_addr_out,
   output logic [ADDR_WIDTH-1:0]         y_bram_addr_out,
   input  logic signed [BIT_DEPTH-1:0]   x_grad_in,
   input  logic signed [BIT_DEPTH-1:0]   y_grad_in,
   output logic signed [BIT_DEPTH-1:0]   x_grad_out,
   output logic signed [BIT_DEPTH-1:0]   y_grad_out,
   output logic [NUM_REQ-1:0]            rvalid_out,
   output logic                          busy_out
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int STAGES = READ_LATENCY + 1;

   logic [PTR_W-1:0]                ptr_q;
   logic [PTR_W-1:0]                ptr_d;
   logic [PTR_W-1:0]                win_idx;
   logic                            win_valid;
   logic [NUM_REQ-1:0]              gnt;
   logic [ADDR_WIDTH-1:0]           x_addr_q;
   logic [ADDR_WIDTH-1:0]           y_addr_q;
   logic [ADDR_WIDTH-1:0]           x_addr_d;
   logic [ADDR_WIDTH-1:0]           y_addr_d;
   logic [STAGES-1:0][NUM_REQ-1:0]  tag_q;

`ifdef GRAD_ARB_BURST_LOCK_EN
   logic                            prev_valid_q;
   logic [PTR_W-1:0]                prev_win_q;
`else
   logic                            lock_unused;
   assign lock_unused = ^lock_in;
`endif

   function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return PTR_W'(sum);
   endfunction

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         if (!win_valid && req_in[rr_idx(ptr_q, off)]) begin
            win_valid = 1'b1;
            win_idx   = rr_idx(ptr_q, off);
         end
      end
`ifdef GRAD_ARB_BURST_LOCK_EN
      // A locked previous winner pre-empts the round-robin search; ptr is already winner+1.
      if (prev_valid_q && req_in[prev_win_q] && lock_in[prev_win_q]) begin
         win_valid = 1'b1;
         win_idx   = prev_win_q;
      end
`endif
      if (!rst_in) win_valid = 1'b0;

      gnt      = win_valid ? (NUM_REQ'(1) << win_idx) : '0;
      ptr_d    = ptr_q;
      x_addr_d = x_addr_q;
      y_addr_d = y_addr_q;
      if (win_valid) begin
         ptr_d    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
         x_addr_d = x_addr_in[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         y_addr_d = y_addr_in[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         ptr_q    <= '0;
         x_addr_q <= '0;
         y_addr_q <= '0;
         // NOTE: the tag pipeline is cleared so reads in flight at reset are never reported.
         tag_q    <= '0;
`ifdef GRAD_ARB_BURST_LOCK_EN
         prev_valid_q <= 1'b0;
         prev_win_q   <= '0;
`endif
      end else begin
         ptr_q    <= ptr_d;
         x_addr_q <= x_addr_d;
         y_addr_q <= y_addr_d;
         tag_q    <= {tag_q[STAGES-2:0], gnt};
`ifdef GRAD_ARB_BURST_LOCK_EN
         prev_valid_q <= win_valid;
         prev_win_q   <= win_idx;
`endif
      end
   end

   assign gnt_out         = gnt;
   assign x_bram_addr_out = x_addr_q;
   assign y_bram_addr_out = y_addr_q;
   assign x_grad_out      = x_grad_in;
   assign y_grad_out      = y_grad_in;
   assign rvalid_out      = rst_in ? tag_q[STAGES-1] : '0;
   assign busy_out        = rst_in & ((|req_in) | (|tag_q));

endmodule
